core_run_ctrl: RTL and testbench
================================

Name: core_run_ctrl

Overview:
- Run/debug sequencer for the single-cycle RISC-V core.
- Loads a program into text memory from a byte stream while holding the core in reset.
- Then runs, halts, single-steps or breakpoints the core by driving its reset and a clock-enable.
- Sits between the board I/O (UART/loader) and the core top level.

Parameters:
ROM_ADDR_WIDTH, 8, text memory word-address width (depth 2^ROM_ADDR_WIDTH words)
CYC_WIDTH, 32, width of the enabled-cycle counter

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset, asynchronous, active-low
load_start  in  1  1-cycle pulse; begin program load
byte_valid  in  1  loader byte valid
byte_data  in  8  loader byte
byte_ready  out  1  ctrl accepts byte
run_cmd  in  1  pulse; run free
halt_cmd  in  1  pulse; stop
step_cmd  in  1  pulse; execute one instruction
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
core_pc  in  32  core's current PC
core_rst  out  1  active-high reset to core
core_clk_en  out  1  core advance enable (combinational)
imem_we  out  1  text memory write strobe
imem_addr  out  ROM_ADDR_WIDTH  text memory write address
imem_wdata  out  32  text memory write data
state  out  3  FSM state, for LEDs/debug
cycle_count  out  CYC_WIDTH  cycles with core_clk_en=1
load_err  out  1  sticky: program exceeded memory depth

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, core_rst=1, core_clk_en=0, byte_ready=0, imem_we=0.
  - imem_addr=0, imem_wdata=0, cycle_count=0, load_err=0.
  - Byte/word counters and bp_skip are cleared.
- Encoding: IDLE=0, LOAD_HDR=1, LOAD_DATA=2, RUN=3, STEP=4, HALT=5.
- core_rst=1 in IDLE, LOAD_HDR and LOAD_DATA; 0 otherwise.
- Byte handshake: a transfer occurs when byte_valid&byte_ready. byte_ready=1 only in LOAD_HDR and LOAD_DATA.
- LOAD_HDR:
  - Two bytes, little-endian 16-bit word count N.
  - N=0: go to IDLE after the second byte.
  - Otherwise go to LOAD_DATA; cycle_count and load_err are cleared on entry.
- LOAD_DATA:
  - Bytes are little-endian within each word: first byte -> wdata[7:0].
  - The cycle after the 4th byte of word k is accepted: imem_we=1 for exactly 1 cycle, imem_addr=k[ROM_ADDR_WIDTH-1:0], imem_wdata=assembled word.
  - Words with k >= 2^ROM_ADDR_WIDTH are still accepted, but imem_we stays 0 and load_err is set.
  - After the last byte of word N-1 is accepted, the next state is IDLE (coincident with its imem_we pulse).
- Transitions from IDLE:
  - load_start -> LOAD_HDR
  - run_cmd -> RUN
  - step_cmd -> STEP
- Transitions from HALT:
  - load_start -> LOAD_HDR
  - run_cmd -> RUN
  - step_cmd -> STEP
- Transitions from RUN:
  - halt_cmd -> HALT
  - breakpoint hit -> HALT
- STEP lasts exactly 1 cycle, then HALT.
- Command priority when simultaneous: halt_cmd > load_start > step_cmd > run_cmd.
- Ignored commands:
  - Commands are ignored during LOAD_HDR and LOAD_DATA.
  - run_cmd is ignored in RUN.
- core_clk_en:
  - STEP: 1, breakpoint ignored.
  - RUN: 1, except 0 when bp_hit = bp_en & (core_pc==bp_addr) & ~bp_skip.
  - All other states: 0.
- Breakpoint hit in RUN: the core does not execute the instruction at bp_addr; next state HALT.
- bp_skip:
  - Set when leaving HALT via run_cmd.
  - Cleared after the first cycle with core_clk_en=1.
  - Effect: resuming at a breakpoint executes that instruction once.
- cycle_count:
  - +1 every cycle with core_clk_en=1.
  - Saturates at all-ones.
  - Held in HALT and IDLE.
- Reset mid-load: full return to the reset state; partially assembled word discarded, no imem_we.

Decomposition:
- Package core_run_ctrl_pkg holds:
  - state encodings (IDLE..HALT)
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
- Natural sub-module: load_word_assembler.
  - Contains the byte counter, 32-bit shift/assemble register, word index and depth check.
  - Outputs: word_done pulse, addr, data, overflow.
- The FSM, breakpoint logic and cycle counter stay in the top module.

Test Plan:
1. Apply rst=0 then release -> state=0, core_rst=1, core_clk_en=0, cycle_count=0, byte_ready=0.
2. load_start, then bytes 02 00 13 05 10 00 B3 05 A5 00 -> imem_we at addr 0 with 0x00100513, then at addr 1 with 0x00A505B3; state=IDLE; load_err=0.
3. Header 00 00 -> back to IDLE, no imem_we pulse.
4. run_cmd with bp_en=1, bp_addr=0x8 -> core_clk_en=1 for 2 cycles, 0 when core_pc=0x8; state=HALT; cycle_count=2. Then run_cmd -> instruction at 0x8 executes, RUN continues.
5. From HALT: step_cmd -> exactly one cycle core_clk_en=1, state returns to 5. halt_cmd+run_cmd in the same cycle while in RUN -> HALT.
6. ROM_ADDR_WIDTH=2, N=5 -> 4 writes at addr 0..3, 5th word gives no imem_we, load_err=1. Reset asserted after 2 bytes of a word -> IDLE, no write, load_err=0.

Source files
------------

// File: rtl/core_run_ctrl_pkg.sv
// core_run_ctrl_pkg: state encodings and loader framing constants for the run/debug sequencer.
package core_run_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_HDR  = 3'd1,
    LOAD_DATA = 3'd2,
    RUN       = 3'd3,
    STEP      = 3'd4,
    HALT      = 3'd5
  } state_t;
  localparam int HDR_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/core_run_ctrl_load_word_assembler.sv
// load_word_assembler: packs little-endian loader bytes into words and issues one write per in-range word.
module load_word_assembler import core_run_ctrl_pkg::*; #(
  parameter int ROM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      take,
  input  logic [7:0]                byte_data,
  output logic                      word_accept,
  output logic [15:0]               word_idx,
  output logic                      word_done,
  output logic [ROM_ADDR_WIDTH-1:0] addr,
  output logic [31:0]               data,
  output logic                      overflow
);
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d, data_q, data_d;
  logic [15:0] idx_q, idx_d;
  logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic done_q, done_d, ovf_q, ovf_d, fits;
  always_comb begin
    word_accept = take && cnt_q == 2'(BYTES_PER_WORD - 1);
    fits = (idx_q >> ROM_ADDR_WIDTH) == 16'd0;
    cnt_d = clear ? 2'd0 : take ? cnt_q + 2'd1 : cnt_q;
    shift_d = clear ? 32'd0 : take ? {byte_data, shift_q[31:8]} : shift_q;
    idx_d = clear ? 16'd0 : word_accept ? idx_q + 16'd1 : idx_q;
    done_d = word_accept && fits;
    ovf_d = word_accept && !fits;
    addr_d = done_d ? idx_q[ROM_ADDR_WIDTH-1:0] : addr_q;
    data_d = done_d ? {byte_data, shift_q[31:8]} : data_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      shift_q <= '0;
      idx_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  assign word_idx = idx_q;
  assign word_done = done_q;
  assign addr = addr_q;
  assign data = data_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: loads a program into text memory, then runs/halts/steps/breakpoints the core.
module core_run_ctrl import core_run_ctrl_pkg::*; #(
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int CYC_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  input  logic                      run_cmd,
  input  logic                      halt_cmd,
  input  logic                      step_cmd,
  input  logic                      bp_en,
  input  logic [31:0]               bp_addr,
  input  logic [31:0]               core_pc,
  output logic                      core_rst,
  output logic                      core_clk_en,
  output logic                      imem_we,
  output logic [ROM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]               imem_wdata,
  output logic [2:0]                state,
  output logic [CYC_WIDTH-1:0]      cycle_count,
  output logic                      load_err
);
  state_t state_q, state_d;
  logic hdr_cnt_q, hdr_cnt_d, skip_q, skip_d, err_q, err_d;
  logic [15:0] n_q, n_d, word_idx;
  logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
  logic xfer, bp_hit, set_skip, enter_data, word_accept, overflow;
  load_word_assembler #(.ROM_ADDR_WIDTH(ROM_ADDR_WIDTH)) u_asm (
    .clk(clk),
    .rst(rst),
    .clear(state_q != LOAD_DATA),
    .take(state_q == LOAD_DATA && byte_valid),
    .byte_data(byte_data),
    .word_accept(word_accept),
    .word_idx(word_idx),
    .word_done(imem_we),
    .addr(imem_addr),
    .data(imem_wdata),
    .overflow(overflow)
  );
  always_comb begin
    state_d = state_q;
    set_skip = 1'b0;
    byte_ready = state_q == LOAD_HDR || state_q == LOAD_DATA;
    core_rst = state_q == IDLE || byte_ready;
    xfer = byte_valid && byte_ready;
    bp_hit = state_q == RUN && bp_en && core_pc == bp_addr && !skip_q;
    core_clk_en = state_q == STEP || (state_q == RUN && !bp_hit);
    hdr_cnt_d = (state_q == LOAD_HDR && xfer) ? ~hdr_cnt_q : hdr_cnt_q;
    n_d = (state_q == LOAD_HDR && xfer) ? (hdr_cnt_q ? {byte_data, n_q[7:0]} : {8'd0, byte_data}) : n_q;
    case (state_q)
      IDLE, HALT:
        if (halt_cmd) state_d = state_q;
        else if (load_start) state_d = LOAD_HDR;
        else if (step_cmd) state_d = STEP;
        else if (run_cmd) begin
          state_d = RUN;
          set_skip = state_q == HALT;
        end
      LOAD_HDR:
        if (xfer && hdr_cnt_q == 1'(HDR_BYTES - 1)) state_d = n_d == 16'd0 ? IDLE : LOAD_DATA;
      LOAD_DATA:
        if (word_accept && word_idx == n_q - 16'd1) state_d = IDLE;
      RUN:
        if (halt_cmd || bp_hit) state_d = HALT;
      STEP:
        state_d = HALT;
      default:
        state_d = IDLE;
    endcase
    enter_data = state_q == LOAD_HDR && state_d == LOAD_DATA;
    cyc_d = enter_data ? '0 : (core_clk_en && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
    err_d = enter_data ? 1'b0 : overflow ? 1'b1 : err_q;
    // Resuming from a breakpoint must let exactly that instruction through once.
    skip_d = set_skip ? 1'b1 : core_clk_en ? 1'b0 : skip_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      hdr_cnt_q <= 1'b0;
      n_q <= '0;
      skip_q <= 1'b0;
      err_q <= 1'b0;
      cyc_q <= '0;
    end else begin
      state_q <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      n_q <= n_d;
      skip_q <= skip_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
    end
  assign state = state_q;
  assign cycle_count = cyc_q;
  assign load_err = err_q;
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench for loader writes plus directed run/step/breakpoint checks.
module tb_core_run_ctrl;
  localparam int AW = 2;
  localparam int CW = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic load_start = 1'b0, byte_valid = 1'b0, run_cmd = 1'b0, halt_cmd = 1'b0, step_cmd = 1'b0, bp_en = 1'b0;
  logic [7:0] byte_data = 8'd0;
  logic [31:0] bp_addr = 32'd0, core_pc;
  logic byte_ready, core_rst, core_clk_en, imem_we, load_err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [2:0] state;
  logic [CW-1:0] cycle_count;
  int total = 0, bad = 0, wr_n = 0;
  typedef struct {logic [AW-1:0] a; logic [31:0] d;} wr_t;
  wr_t exp_q[$];

  core_run_ctrl #(.ROM_ADDR_WIDTH(AW), .CYC_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .run_cmd(run_cmd), .halt_cmd(halt_cmd), .step_cmd(step_cmd),
    .bp_en(bp_en), .bp_addr(bp_addr), .core_pc(core_pc), .core_rst(core_rst), .core_clk_en(core_clk_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .state(state),
    .cycle_count(cycle_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) core_pc <= 32'd0;
    else if (core_rst) core_pc <= 32'd0;
    else if (core_clk_en) core_pc <= core_pc + 32'd4;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && imem_we) begin
      wr_t e;
      wr_n++;
      if (exp_q.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e.a);
        check("wr_data", imem_wdata, e.d);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c);
    {halt_cmd, load_start, step_cmd, run_cmd} = c;
    tick();
    {halt_cmd, load_start, step_cmd, run_cmd} = 4'd0;
  endtask

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    byte_valid = 1'b1;
    byte_data = b;
    while (!byte_ready && w < 10) begin
      tick();
      w++;
    end
    if (!byte_ready) check("byte_ready_timeout", byte_ready, 1);
    else tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_wr, input logic [AW-1:0] a);
    wr_t e;
    e.a = a;
    e.d = w;
    if (expect_wr) exp_q.push_back(e);
    send(w[7:0]);
    send(w[15:8]);
    send(w[23:16]);
    send(w[31:24]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int en_n;
    #12;
    check("rst_state", state, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_clk_en", core_clk_en, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_err", load_err, 0);
    rst = 1'b1;
    tick();
    check("idle_after_rst", state, 0);
    // two-word program load
    cmd(4'b0100);
    check("hdr_state", state, 1);
    check("hdr_ready", byte_ready, 1);
    send(8'h02);
    send(8'h00);
    check("data_state", state, 2);
    send_word(32'h00100513, 1, 0);
    send_word(32'h00A505B3, 1, 1);
    check("load_done_state", state, 0);
    tick();
    tick();
    check("load_wr_count", wr_n, 2);
    check("load_queue_empty", exp_q.size(), 0);
    check("load_err_clean", load_err, 0);
    // empty program
    cmd(4'b0100);
    send(8'h00);
    send(8'h00);
    check("n0_state", state, 0);
    repeat (3) tick();
    check("n0_no_write", wr_n, 2);
    // breakpoint at 0x8
    bp_en = 1'b1;
    bp_addr = 32'h8;
    cmd(4'b0001);
    check("run_state", state, 3);
    check("run_core_rst", core_rst, 0);
    en_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 3'd5) break;
      if (core_clk_en) en_n++;
      if (core_pc == 32'h8) check("bp_stall", core_clk_en, 0);
    end
    check("bp_halt_state", state, 5);
    check("bp_en_cycles", en_n, 2);
    check("bp_pc", core_pc, 32'h8);
    check("bp_cycles", cycle_count, 2);
    tick();
    cmd(4'b0001);
    check("resume_state", state, 3);
    check("resume_pc", core_pc, 32'h8);
    check("resume_clk_en", core_clk_en, 1);
    tick();
    check("resume_cont_state", state, 3);
    check("resume_cont_pc", core_pc, 32'hC);
    cmd(4'b1001);
    check("halt_prio_state", state, 5);
    check("halt_prio_pc", core_pc, 32'h10);
    check("halt_cycles", cycle_count, 4);
    check("halt_clk_en", core_clk_en, 0);
    // single step
    cmd(4'b0010);
    check("step_state", state, 4);
    check("step_clk_en", core_clk_en, 1);
    tick();
    check("step_back_halt", state, 5);
    check("step_pc", core_pc, 32'h14);
    check("step_cycles", cycle_count, 5);
    // load beats step
    cmd(4'b0110);
    check("load_prio_state", state, 1);
    send(8'h00);
    send(8'h00);
    check("load_prio_idle", state, 0);
    check("cycles_held", cycle_count, 5);
    // counter saturation
    bp_en = 1'b0;
    cmd(4'b0001);
    repeat (15) tick();
    check("sat_state", state, 3);
    check("sat_cycles", cycle_count, 15);
    cmd(4'b1000);
    check("sat_halt", state, 5);
    // overflow past memory depth
    cmd(4'b0100);
    send(8'h05);
    send(8'h00);
    check("ovf_data_state", state, 2);
    check("ovf_cycles_clr", cycle_count, 0);
    for (int k = 0; k < 5; k++) send_word($urandom, k < 4, AW'(k));
    check("ovf_done_state", state, 0);
    tick();
    tick();
    check("ovf_err", load_err, 1);
    check("ovf_wr_count", wr_n, 6);
    check("ovf_queue_empty", exp_q.size(), 0);
    // reset mid-word
    cmd(4'b0100);
    send(8'h01);
    send(8'h00);
    send(8'hAA);
    send(8'hBB);
    check("mid_state", state, 2);
    rst = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_err", load_err, 0);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_data", imem_wdata, 0);
    check("mid_rst_ready", byte_ready, 0);
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("mid_no_write", wr_n, 6);
    check("mid_idle", state, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
